// File: rtl/aes_inv_key_schedule.sv
// Inverse AES-128 key schedule: loads the round-10 key and walks back one round key
// per step request, using one shared forward S-box over four cycles per round.

module aes_sbox (
  input  logic       inv_en,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128; zero maps to zero as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input logic [2:0] n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  logic [7:0] fwd_inv_s;
  logic [7:0] inv_aff_s;

  // Forward: inverse then affine; inverse: inverse affine then field inverse
  always_comb begin
    fwd_inv_s = gf_inv(din);
    inv_aff_s = rotl8(din, 3'd1) ^ rotl8(din, 3'd3) ^ rotl8(din, 3'd6) ^ 8'h05;
    if (inv_en) begin
      dout = gf_inv(inv_aff_s);
    end else begin
      dout = fwd_inv_s ^ rotl8(fwd_inv_s, 3'd1) ^ rotl8(fwd_inv_s, 3'd2)
           ^ rotl8(fwd_inv_s, 3'd3) ^ rotl8(fwd_inv_s, 3'd4) ^ 8'h63;
    end
  end

endmodule

module aes_inv_key_schedule #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [127:0] key_in,
  input  logic         step,
  output logic [127:0] round_key_o,
  output logic [3:0]   round_o,
  output logic         key_valid,
  output logic         busy,
  output logic         step_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, SUB = 2'd2, FIN = 2'd3} state_t;

  state_t          state_r, state_nxt_s;
  logic [1:0]      cnt_r, cnt_nxt_s;
  logic [3:0][7:0] sb_r, sb_nxt_s;
  logic [127:0]    key_r, key_nxt_s;
  logic [3:0]      round_r, round_nxt_s;
  logic            valid_r, valid_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic            err_r, err_nxt_s;

  logic [31:0]     n0_s, n1_s, n2_s, n3_s, t_s, sub_word_s;
  logic [7:0]      sbox_in_s, sbox_out_s;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Previous-round words and the S-box byte selected by cnt
  always_comb begin
    n3_s       = key_r[31:0]   ^ key_r[63:32];
    n2_s       = key_r[63:32]  ^ key_r[95:64];
    n1_s       = key_r[95:64]  ^ key_r[127:96];
    t_s        = {n3_s[23:0], n3_s[31:24]};
    sub_word_s = {sb_r[0], sb_r[1], sb_r[2], sb_r[3]};
    n0_s       = key_r[127:96] ^ sub_word_s ^ {rcon(round_r), 24'h000000};
    case (cnt_r)
      2'd0:    sbox_in_s = t_s[31:24];
      2'd1:    sbox_in_s = t_s[23:16];
      2'd2:    sbox_in_s = t_s[15:8];
      2'd3:    sbox_in_s = t_s[7:0];
      default: sbox_in_s = 8'h00;
    endcase
  end

  aes_sbox u_sbox (
    .inv_en (1'b0),
    .din    (sbox_in_s),
    .dout   (sbox_out_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; load overrides everything
  always_comb begin
    state_nxt_s = state_r;
    if (load) begin
      state_nxt_s = READY;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = IDLE;
        READY:   state_nxt_s = (step && (round_r != 4'd0)) ? SUB : READY;
        SUB:     state_nxt_s = (cnt_r == 2'd3) ? FIN : SUB;
        FIN:     state_nxt_s = READY;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    key_nxt_s   = key_r;
    round_nxt_s = round_r;
    valid_nxt_s = valid_r;
    busy_nxt_s  = busy_r;
    err_nxt_s   = 1'b0;
    cnt_nxt_s   = cnt_r;
    sb_nxt_s    = sb_r;
    if (load) begin
      key_nxt_s   = key_in;
      round_nxt_s = 4'(NR);
      valid_nxt_s = 1'b1;
      busy_nxt_s  = 1'b0;
      cnt_nxt_s   = 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          err_nxt_s = step;
        end
        READY: begin
          if (step && (round_r != 4'd0)) begin
            cnt_nxt_s   = 2'd0;
            busy_nxt_s  = 1'b1;
            valid_nxt_s = 1'b0;
          end else begin
            err_nxt_s = step;
          end
        end
        SUB: begin
          sb_nxt_s[cnt_r] = sbox_out_s;
          cnt_nxt_s       = cnt_r + 2'd1;
          err_nxt_s       = step;
        end
        FIN: begin
          key_nxt_s   = {n0_s, n1_s, n2_s, n3_s};
          round_nxt_s = round_r - 4'd1;
          busy_nxt_s  = 1'b0;
          valid_nxt_s = 1'b1;
          err_nxt_s   = step;
        end
        default: begin
          err_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r   <= 128'h0;
      round_r <= 4'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= 2'd0;
      sb_r    <= 32'h0;
    end else begin
      key_r   <= key_nxt_s;
      round_r <= round_nxt_s;
      valid_r <= valid_nxt_s;
      busy_r  <= busy_nxt_s;
      err_r   <= err_nxt_s;
      cnt_r   <= cnt_nxt_s;
      sb_r    <= sb_nxt_s;
    end
  end

  assign round_key_o = key_r;
  assign round_o     = round_r;
  assign key_valid   = valid_r;
  assign busy        = busy_r;
  assign step_err    = err_r;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule: FIPS-197 round keys as reference,
// completed derivations compared through a scoreboard queue.

module tb_aes_inv_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [127:0] key_in;
  logic         step;
  logic [127:0] round_key_o;
  logic [3:0]   round_o;
  logic         key_valid;
  logic         busy;
  logic         step_err;

  aes_inv_key_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .key_in      (key_in),
    .step        (step),
    .round_key_o (round_key_o),
    .round_o     (round_o),
    .key_valid   (key_valid),
    .busy        (busy),
    .step_err    (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] rk [0:10] = '{
    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
    128'ha0fafe17_88542cb1_23a33939_2a6c7605,
    128'hf2c295f2_7a96b943_5935807a_7359f67f,
    128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
    128'hef44a541_a8525b7f_b671253b_db0bad00,
    128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
    128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
    128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
    128'head27321_b58dbad2_312bf560_7f8d292f,
    128'hac7766f3_19fadc21_28d12941_575c006e,
    128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
  };

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   rnd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Completion monitor: a busy fall leaving a valid, non-reloaded key is a derived key
  initial begin : monitor
    exp_t e;
    int   busy_len;
    logic busy_prev;
    busy_len  = 0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) begin
        busy_len++;
      end else begin
        if (busy_prev && key_valid && (round_o != 4'd10)) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_unexpected", 128'(exp_q.size()), 128'd1);
          end else begin
            e = exp_q.pop_front();
            check_eq("sb_key", round_key_o, e.key);
            check_eq("sb_round", 128'(round_o), 128'(e.rnd));
            check_eq("sb_busy_cycles", 128'(busy_len), 128'd5);
          end
        end
        busy_len = 0;
      end
      busy_prev = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check_eq("sb_drain", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic do_load(input logic [127:0] k);
    key_in = k;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic do_step(input logic [3:0] from_rnd);
    exp_q.push_back('{key: rk[from_rnd - 4'd1], rnd: from_rnd - 4'd1});
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("step_busy", 128'(busy), 128'd1);
    wait_sb();
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    step   = 1'b0;
    key_in = 128'h0;
    tick();
    check_eq("rst_key", round_key_o, 128'h0);
    check_eq("rst_round", 128'(round_o), 128'd0);
    check_eq("rst_valid", 128'(key_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_err", 128'(step_err), 128'd0);
    rst_n = 1'b1;
    tick();

    // step before any load
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("noload_err", 128'(step_err), 128'd1);
    check_eq("noload_valid", 128'(key_valid), 128'd0);
    tick();
    check_eq("noload_err_pulse", 128'(step_err), 128'd0);

    // load round-10 key, first step
    do_load(rk[10]);
    check_eq("load_valid", 128'(key_valid), 128'd1);
    check_eq("load_round", 128'(round_o), 128'd10);
    check_eq("load_key", round_key_o, rk[10]);
    do_step(4'd10);

    // walk back to the cipher key
    for (int r = 9; r >= 1; r--) begin
      do_step(4'(r));
    end
    check_eq("r0_key", round_key_o, rk[0]);
    check_eq("r0_round", 128'(round_o), 128'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("r0_step_err", 128'(step_err), 128'd1);
    check_eq("r0_key_kept", round_key_o, rk[0]);
    check_eq("r0_round_kept", 128'(round_o), 128'd0);
    check_eq("r0_not_busy", 128'(busy), 128'd0);

    // step held high for the whole derivation
    do_load(rk[10]);
    exp_q.push_back('{key: rk[9], rnd: 4'd9});
    step = 1'b1;
    tick();
    check_eq("hold_accept_err", 128'(step_err), 128'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("hold_busy_err", 128'(step_err), 128'd1);
      check_eq("hold_key_stable", round_key_o, rk[10]);
    end
    step = 1'b0;
    wait_sb();

    // load aborting a step at cnt=2
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    do_load(rk[10]);
    check_eq("abort_key", round_key_o, rk[10]);
    check_eq("abort_round", 128'(round_o), 128'd10);
    check_eq("abort_busy", 128'(busy), 128'd0);
    check_eq("abort_valid", 128'(key_valid), 128'd1);

    // simultaneous load and step
    key_in = 128'h00112233_44556677_8899aabb_ccddeeff;
    load   = 1'b1;
    step   = 1'b1;
    tick();
    load   = 1'b0;
    step   = 1'b0;
    check_eq("ls_key", round_key_o, 128'h00112233_44556677_8899aabb_ccddeeff);
    check_eq("ls_round", 128'(round_o), 128'd10);
    check_eq("ls_err", 128'(step_err), 128'd0);
    check_eq("ls_busy", 128'(busy), 128'd0);
    tick();
    check_eq("ls_busy_after", 128'(busy), 128'd0);

    // asynchronous reset in the middle of SUB
    do_load(rk[10]);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_key", round_key_o, 128'h0);
    check_eq("arst_round", 128'(round_o), 128'd0);
    check_eq("arst_valid", 128'(key_valid), 128'd0);
    check_eq("arst_busy", 128'(busy), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("arst_idle_err", 128'(step_err), 128'd1);
    check_eq("arst_idle_valid", 128'(key_valid), 128'd0);
    tick();
    tick();
    check_eq("final_queue", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
